// File: rtl/muntjac_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muntjac_fetch_queue: in-order fetch-to-decode circular queue, opt bypass |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module muntjac_fetch_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned EX_WIDTH    = 68,
  parameter bit          BYPASS      = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [PC_WIDTH-1:0]          in_pc_i,
  input  logic [3:0]                   in_if_reason_i,
  input  logic [INSTR_WIDTH-1:0]       in_instr_i,
  input  logic                         in_ex_valid_i,
  input  logic [EX_WIDTH-1:0]          in_exception_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PC_WIDTH-1:0]          out_pc_o,
  output logic [3:0]                   out_if_reason_o,
  output logic [INSTR_WIDTH-1:0]       out_instr_o,
  output logic                         out_ex_valid_o,
  output logic [EX_WIDTH-1:0]          out_exception_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);
  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_ent_w = PC_WIDTH + 4 + INSTR_WIDTH + 1 + EX_WIDTH;
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [c_ent_w-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic               w_empty;
  logic               w_byp_fire;
  logic               w_out_valid;
  logic               w_enq;
  logic               w_deq;
  logic [c_ent_w-1:0] w_in_ent;
  logic [c_ent_w-1:0] w_out_ent;

  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  assign w_empty    = (r_count == '0);
  assign in_ready_o = (r_count != c_full_cnt);
  assign w_in_ent   = {in_pc_i, in_if_reason_i, in_instr_i, in_ex_valid_i, in_exception_i};

  // With an empty queue the bypass path presents the input directly to decode.
  if (BYPASS) begin : g_bypass
    assign w_byp_fire  = w_empty & in_valid_i & out_ready_i & ~flush_i;
    assign w_out_valid = ~flush_i & (w_empty ? in_valid_i : 1'b1);
    assign w_out_ent   = w_empty ? w_in_ent : r_mem[r_rd_ptr];
  end else begin : g_no_bypass
    assign w_byp_fire  = 1'b0;
    assign w_out_valid = ~flush_i & ~w_empty;
    assign w_out_ent   = r_mem[r_rd_ptr];
  end

  assign w_enq = in_valid_i & in_ready_o & ~flush_i & ~w_byp_fire;
  assign w_deq = w_out_valid & out_ready_i & ~w_empty;

  // Reset is asynchronous, so valid is masked while it is held.
  assign out_valid_o = w_out_valid & ~rst_i;
  assign {out_pc_o, out_if_reason_o, out_instr_o, out_ex_valid_o, out_exception_o} = w_out_ent;
  assign count_o = r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_deq) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      if (w_enq && !w_deq) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  // Payload storage is never cleared; only the pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= w_in_ent;
  end

endmodule
`default_nettype wire

// File: tb/tb_muntjac_fetch_queue.sv
`default_nettype none
// tb_muntjac_fetch_queue: directed self-checking bench over three queue configurations.
module tb_muntjac_fetch_queue;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Instance A: DEPTH=4, BYPASS=0
  logic        a_flush, a_iv, a_ir, a_exv, a_ov, a_ordy, a_oexv;
  logic [63:0] a_pc, a_opc;
  logic [3:0]  a_rsn, a_orsn;
  logic [31:0] a_instr, a_oinstr;
  logic [67:0] a_ex, a_oex;
  logic [2:0]  a_cnt;

  // Instance B: DEPTH=3, BYPASS=0
  logic        b_flush, b_iv, b_ir, b_exv, b_ov, b_ordy, b_oexv;
  logic [63:0] b_pc, b_opc;
  logic [3:0]  b_rsn, b_orsn;
  logic [31:0] b_instr, b_oinstr;
  logic [67:0] b_ex, b_oex;
  logic [1:0]  b_cnt;

  // Instance C: DEPTH=4, BYPASS=1
  logic        c_flush, c_iv, c_ir, c_exv, c_ov, c_ordy, c_oexv;
  logic [63:0] c_pc, c_opc;
  logic [3:0]  c_rsn, c_orsn;
  logic [31:0] c_instr, c_oinstr;
  logic [67:0] c_ex, c_oex;
  logic [2:0]  c_cnt;

  muntjac_fetch_queue #(.DEPTH(4), .BYPASS(1'b0)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(a_flush),
    .in_valid_i(a_iv), .in_ready_o(a_ir), .in_pc_i(a_pc), .in_if_reason_i(a_rsn),
    .in_instr_i(a_instr), .in_ex_valid_i(a_exv), .in_exception_i(a_ex),
    .out_valid_o(a_ov), .out_ready_i(a_ordy), .out_pc_o(a_opc), .out_if_reason_o(a_orsn),
    .out_instr_o(a_oinstr), .out_ex_valid_o(a_oexv), .out_exception_o(a_oex), .count_o(a_cnt)
  );

  muntjac_fetch_queue #(.DEPTH(3), .BYPASS(1'b0)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(b_flush),
    .in_valid_i(b_iv), .in_ready_o(b_ir), .in_pc_i(b_pc), .in_if_reason_i(b_rsn),
    .in_instr_i(b_instr), .in_ex_valid_i(b_exv), .in_exception_i(b_ex),
    .out_valid_o(b_ov), .out_ready_i(b_ordy), .out_pc_o(b_opc), .out_if_reason_o(b_orsn),
    .out_instr_o(b_oinstr), .out_ex_valid_o(b_oexv), .out_exception_o(b_oex), .count_o(b_cnt)
  );

  muntjac_fetch_queue #(.DEPTH(4), .BYPASS(1'b1)) u_c (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(c_flush),
    .in_valid_i(c_iv), .in_ready_o(c_ir), .in_pc_i(c_pc), .in_if_reason_i(c_rsn),
    .in_instr_i(c_instr), .in_ex_valid_i(c_exv), .in_exception_i(c_ex),
    .out_valid_o(c_ov), .out_ready_i(c_ordy), .out_pc_o(c_opc), .out_if_reason_o(c_orsn),
    .out_instr_o(c_oinstr), .out_ex_valid_o(c_oexv), .out_exception_o(c_oex), .count_o(c_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] exp_pc;
  int          sent;
  int          rcvd;
  int          cyc;

  initial begin
    {a_flush, a_iv, a_exv, a_ordy, a_pc, a_rsn, a_instr, a_ex} = '0;
    {b_flush, b_iv, b_exv, b_ordy, b_pc, b_rsn, b_instr, b_ex} = '0;
    {c_flush, c_iv, c_exv, c_ordy, c_pc, c_rsn, c_instr, c_ex} = '0;
    a_rsn = 4'b0010; b_rsn = 4'b0010; c_rsn = 4'b0010;

    // Reset state, including BYPASS=1 with input offered during reset
    c_iv = 1'b1; c_ordy = 1'b1; c_pc = 64'h9999;
    #12;
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_ov", a_ov, 0);
    chk("rst_a_ir", a_ir, 1);
    chk("rst_c_ov", c_ov, 0);
    c_iv = 1'b0; c_ordy = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;

    // A: fill 4 entries with decoder stalled
    for (int i = 0; i < 4; i++) begin
      a_iv = 1'b1; a_pc = 64'h1000 + 64'(4 * i); a_instr = 32'(i);
      tick();
      chk("fill_cnt", a_cnt, i + 1);
    end
    a_pc = 64'hDEAD;
    #1;
    chk("full_ir", a_ir, 0);
    chk("full_head", a_opc, 64'h1000);
    tick();
    a_iv = 1'b0;
    chk("full_reject_cnt", a_cnt, 4);

    // A: drain in order
    a_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_ov", a_ov, 1);
      chk("drain_pc", a_opc, 64'h1000 + 64'(4 * i));
      chk("drain_cnt", a_cnt, 4 - i);
      tick();
    end
    chk("drained_cnt", a_cnt, 0);
    chk("drained_ov", a_ov, 0);

    // A: shift pointers off zero, then fill and flush with an input offered
    a_iv = 1'b1; a_pc = 64'h10F0; a_ordy = 1'b0;
    tick();
    a_iv = 1'b0; a_ordy = 1'b1;
    tick();
    a_ordy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_iv = 1'b1; a_pc = 64'h1100 + 64'(4 * i);
      tick();
    end
    chk("prefl_cnt", a_cnt, 4);
    a_flush = 1'b1; a_iv = 1'b1; a_pc = 64'h3000; a_ordy = 1'b1;
    #1;
    chk("flush_ov", a_ov, 0);
    tick();
    a_flush = 1'b0; a_iv = 1'b0; a_ordy = 1'b0;
    #1;
    chk("postfl_cnt", a_cnt, 0);
    chk("postfl_ov", a_ov, 0);
    chk("postfl_ir", a_ir, 1);
    a_iv = 1'b1; a_pc = 64'h1200; a_rsn = 4'b0001;
    tick();
    a_iv = 1'b0; a_rsn = 4'b0010;
    chk("postfl_head_pc", a_opc, 64'h1200);
    chk("postfl_reason_nonprefetch", (a_orsn[1:0] != 2'b00), 1);
    a_ordy = 1'b1;
    tick();
    chk("postfl_empty", a_cnt, 0);

    // A: simultaneous push and pop at count=2, exception payload pass-through
    a_ordy = 1'b0;
    a_iv = 1'b1; a_pc = 64'h4000; tick();
    a_pc = 64'h4004; tick();
    a_pc = 64'h4008; a_exv = 1'b1; a_ex = 68'h5_0000000000000ABC; a_ordy = 1'b1;
    #1;
    chk("pp_cnt_before", a_cnt, 2);
    chk("pp_head0", a_opc, 64'h4000);
    tick();
    a_iv = 1'b0; a_exv = 1'b0; a_ex = '0;
    chk("pp_cnt_after", a_cnt, 2);
    chk("pp_head1", a_opc, 64'h4004);
    tick();
    chk("ex_pc", a_opc, 64'h4008);
    chk("ex_valid", a_oexv, 1);
    chk("ex_payload", a_oex, 68'h5_0000000000000ABC);
    chk("ex_cnt", a_cnt, 1);
    tick();
    chk("ex_drained", a_cnt, 0);

    // A: asynchronous reset with 3 entries held
    a_ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_iv = 1'b1; a_pc = 64'h6000 + 64'(4 * i);
      tick();
    end
    a_iv = 1'b0;
    chk("arst_pre_cnt", a_cnt, 3);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_ov", a_ov, 0);
    chk("arst_cnt", a_cnt, 0);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_ir", a_ir, 1);
    chk("arst_ov_after", a_ov, 0);
    tick();

    // B: DEPTH=3 wrap-around, 10 entries, decoder ready toggling
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 10 && cyc < 100) begin
      b_ordy = cyc[0] ? 1'b0 : 1'b1;
      b_iv   = (sent < 10);
      b_pc   = 64'h5000 + 64'(4 * sent);
      #1;
      chk("wrap_cnt", b_cnt, exp_q.size());
      chk("wrap_ir", b_ir, (exp_q.size() != 3));
      if (b_ov && b_ordy) begin
        exp_pc = exp_q.pop_front();
        chk("wrap_pc", b_opc, exp_pc);
        rcvd++;
      end
      if (b_iv && b_ir) begin
        exp_q.push_back(b_pc);
        sent++;
      end
      tick();
      cyc++;
    end
    b_iv = 1'b0; b_ordy = 1'b0;
    chk("wrap_rcvd", rcvd, 10);

    // C: BYPASS=1 same-cycle pass-through
    c_iv = 1'b1; c_ordy = 1'b1; c_pc = 64'h2000; c_instr = 32'h00000013;
    #1;
    chk("byp_ov", c_ov, 1);
    chk("byp_pc", c_opc, 64'h2000);
    chk("byp_instr", c_oinstr, 32'h00000013);
    chk("byp_cnt", c_cnt, 0);
    tick();
    chk("byp_cnt_next", c_cnt, 0);
    c_ordy = 1'b0; c_pc = 64'h2004;
    #1;
    chk("byp_stall_ov", c_ov, 1);
    chk("byp_stall_pc", c_opc, 64'h2004);
    tick();
    c_iv = 1'b0;
    chk("byp_stored_cnt", c_cnt, 1);
    chk("byp_stored_pc", c_opc, 64'h2004);
    c_ordy = 1'b1;
    tick();
    chk("byp_stored_drained", c_cnt, 0);
    c_iv = 1'b1; c_flush = 1'b1; c_pc = 64'h2008;
    #1;
    chk("byp_flush_ov", c_ov, 0);
    tick();
    c_iv = 1'b0; c_flush = 1'b0;
    chk("byp_flush_cnt", c_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
